// File: rtl/ctu_clsp_clkgn_coin_pkg.sv
// Shared definitions for the CTU cluster sync coincidence-lock stage.
// State encoding and the sync-period width are shared with the sync-pulse generator.
package ctu_clsp_clkgn_coin_pkg;

    localparam int SYNC_PERIOD_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_LOCK = 2'd2,
        ST_RUN  = 2'd3
    } coin_state_e;

endpackage

// File: rtl/ctu_clsp_coin_phcnt.sv
// Phase down-counter tracking the expected coin_edge slot,
// with match/mismatch decode against the incoming edge.
module ctu_clsp_coin_phcnt
    import ctu_clsp_clkgn_coin_pkg::*;
(
    input  logic                     cmp_clk,
    input  logic                     start_clk_early_jl,
    input  logic                     run,
    input  logic                     load,
    input  logic                     clear,
    input  logic [SYNC_PERIOD_W-1:0] period,
    input  logic                     coin_edge,
    output logic                     match,
    output logic                     mismatch
);

    logic [SYNC_PERIOD_W-1:0] phase_cnt;
    logic                     zero;

    assign zero = (phase_cnt == '0);

    // Edge exactly at zero is on time; edge early or zero without edge is a miss.
    assign match    = coin_edge & zero;
    assign mismatch = coin_edge ^ zero;

    always_ff @(posedge cmp_clk or negedge start_clk_early_jl) begin
        if (!start_clk_early_jl) begin
            phase_cnt <= '0;
        end else if (clear) begin
            phase_cnt <= '0;
        end else if (load) begin
            phase_cnt <= period;
        end else if (run && !zero) begin
            phase_cnt <= phase_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ctu_clsp_clkgn_coin.sv
// Coincidence-lock FSM: qualifies periodic coin_edge pulses, then issues
// a one-shot phase load and holds compare-enable while lock is held.
module ctu_clsp_clkgn_coin
    import ctu_clsp_clkgn_coin_pkg::*;
#(
    parameter int LOCK_CNT = 4
) (
    input  logic                     cmp_clk,
    input  logic                     start_clk_early_jl,
    input  logic                     clsp_coin_start,
    input  logic                     coin_edge,
    input  logic [SYNC_PERIOD_W-1:0] clsp_sync_period,
    output logic                     coin_cnt_ld,
    output logic                     coin_cnt_en,
    output logic                     coin_locked,
    output logic                     coin_err
);

    coin_state_e state;
    logic [2:0]  match_cnt;
    logic        match;
    logic        mismatch;
    logic        ph_run;
    logic        ph_load;
    logic        ph_clear;
    logic        lock_last;

    // The arming edge counts as the first coincidence of the run.
    assign lock_last = (int'(match_cnt) + 2 >= LOCK_CNT);

    always_comb begin
        ph_run   = (state == ST_LOCK) || (state == ST_RUN);
        ph_load  = 1'b0;
        ph_clear = !clsp_coin_start;
        if (clsp_coin_start) begin
            unique case (1'b1)
                (state == ST_ARM):  ph_load = coin_edge;
                (state == ST_LOCK): begin
                    ph_load  = coin_edge;
                    ph_clear = mismatch && !coin_edge;
                end
                (state == ST_RUN): begin
                    ph_load  = match;
                    ph_clear = mismatch;
                end
                default: ;
            endcase
        end
    end

    ctu_clsp_coin_phcnt u_phcnt (
        .cmp_clk            (cmp_clk),
        .start_clk_early_jl (start_clk_early_jl),
        .run                (ph_run),
        .load               (ph_load),
        .clear              (ph_clear),
        .period             (clsp_sync_period),
        .coin_edge          (coin_edge),
        .match              (match),
        .mismatch           (mismatch)
    );

    always_ff @(posedge cmp_clk or negedge start_clk_early_jl) begin
        if (!start_clk_early_jl) begin
            state       <= ST_IDLE;
            match_cnt   <= '0;
            coin_cnt_ld <= 1'b0;
            coin_cnt_en <= 1'b0;
            coin_locked <= 1'b0;
            coin_err    <= 1'b0;
        end else if (!clsp_coin_start) begin
            state       <= ST_IDLE;
            match_cnt   <= '0;
            coin_cnt_ld <= 1'b0;
            coin_cnt_en <= 1'b0;
            coin_locked <= 1'b0;
            coin_err    <= 1'b0;
        end else begin
            coin_cnt_ld <= 1'b0;
            unique case (state)
                ST_IDLE: state <= ST_ARM;
                ST_ARM: begin
                    if (coin_edge) begin
                        match_cnt <= '0;
                        if (LOCK_CNT == 1) begin
                            state       <= ST_RUN;
                            coin_cnt_ld <= 1'b1;
                            coin_cnt_en <= 1'b1;
                            coin_locked <= 1'b1;
                        end else begin
                            state <= ST_LOCK;
                        end
                    end
                end
                ST_LOCK: begin
                    if (match) begin
                        if (lock_last) begin
                            state       <= ST_RUN;
                            match_cnt   <= '0;
                            coin_cnt_ld <= 1'b1;
                            coin_cnt_en <= 1'b1;
                            coin_locked <= 1'b1;
                        end else begin
                            match_cnt <= match_cnt + 3'd1;
                        end
                    end else if (mismatch) begin
                        match_cnt <= '0;
                        if (!coin_edge) begin
                            state <= ST_ARM;
                        end
                    end
                end
                ST_RUN: begin
                    // A mismatching edge is dropped, not reused as an arming edge.
                    if (mismatch) begin
                        state       <= ST_ARM;
                        match_cnt   <= '0;
                        coin_cnt_en <= 1'b0;
                        coin_locked <= 1'b0;
                        coin_err    <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctu_clsp_clkgn_coin.sv
// Directed table-driven bench for the coincidence-lock stage.
// Row k = inputs sampled at clock k; expected = outputs just after that clock.
module tb_ctu_clsp_clkgn_coin;

    typedef struct {
        logic       start;
        logic       edge_in;
        logic [4:0] period;
        logic       ld;
        logic       en;
        logic       locked;
        logic       err;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       coin_edge;
    logic [4:0] period;
    logic       ld;
    logic       en;
    logic       locked;
    logic       err;

    int   n_chk;
    int   n_fail;
    vec_t vec[$];

    ctu_clsp_clkgn_coin #(.LOCK_CNT(4)) dut (
        .cmp_clk            (clk),
        .start_clk_early_jl (rst_n),
        .clsp_coin_start    (start),
        .coin_edge          (coin_edge),
        .clsp_sync_period   (period),
        .coin_cnt_ld        (ld),
        .coin_cnt_en        (en),
        .coin_locked        (locked),
        .coin_err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, int k, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b expected %b", name, k, act, exp);
        end
    endtask

    task automatic add(logic s, logic e, logic [4:0] p,
                       logic l, logic n, logic r);
        vec_t v;
        v.start   = s;
        v.edge_in = e;
        v.period  = p;
        v.ld      = l;
        v.en      = n;
        v.locked  = n;
        v.err     = r;
        vec.push_back(v);
    endtask

    task automatic run_table(string name);
        for (int k = 0; k < vec.size(); k++) begin
            @(negedge clk);
            start     = vec[k].start;
            coin_edge = vec[k].edge_in;
            period    = vec[k].period;
            @(posedge clk);
            #1;
            check({name, ".ld"}, k, ld, vec[k].ld);
            check({name, ".en"}, k, en, vec[k].en);
            check({name, ".locked"}, k, locked, vec[k].locked);
            check({name, ".err"}, k, err, vec[k].err);
        end
        vec.delete();
    endtask

    // Reset is pulled between clock edges; outputs must clear without a clock.
    task automatic do_reset(string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({name, ".rst_ld"}, 0, ld, 1'b0);
        check({name, ".rst_en"}, 0, en, 1'b0);
        check({name, ".rst_locked"}, 0, locked, 1'b0);
        check({name, ".rst_err"}, 0, err, 1'b0);
        start     = 1'b0;
        coin_edge = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic build_a(int last);
        for (int k = 0; k <= last; k++)
            add(1'b1, k >= 10 && (k - 10) % 6 == 0, 5'd5,
                k == 28, k >= 28, 1'b0);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        coin_edge = 1'b0;
        period    = 5'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.ld", 0, ld, 1'b0);
        check("reset.en", 0, en, 1'b0);
        check("reset.locked", 0, locked, 1'b0);
        check("reset.err", 0, err, 1'b0);

        // In-phase lock: edges every 6 cycles from 10, lock on edge 28.
        build_a(40);
        run_table("inphase");

        // Async reset while RUN, then while LOCK with two matches counted.
        do_reset("run_reset");
        build_a(23);
        run_table("lock_pre");
        do_reset("lock_reset");
        build_a(40);
        run_table("relock");
        do_reset("b");

        // Early edge at 19 restarts the count.
        for (int k = 0; k <= 44; k++)
            add(1'b1, k == 10 || k == 16 || (k >= 19 && (k - 19) % 6 == 0),
                5'd5, k == 37, k >= 37, 1'b0);
        run_table("early");
        do_reset("g");

        // Missing edge at 22 while LOCK drops back to ARM.
        for (int k = 0; k <= 45; k++)
            add(1'b1, k == 10 || k == 16 || (k >= 25 && (k - 25) % 6 == 0),
                5'd5, k == 43, k >= 43, 1'b0);
        run_table("lock_miss");
        do_reset("c");

        // Missing edge at 40 while RUN: error, sticky, relock at 64.
        for (int k = 0; k <= 66; k++)
            add(1'b1, k >= 10 && (k - 10) % 6 == 0 && k != 40, 5'd5,
                k == 28 || k == 64, (k >= 28 && k < 40) || k >= 64, k >= 40);
        run_table("run_miss");
        do_reset("h");

        // Early edge at 37 in RUN is not reused for arming.
        for (int k = 0; k <= 63; k++)
            add(1'b1,
                (k >= 10 && k <= 34 && (k - 10) % 6 == 0) || k == 37 ||
                (k >= 43 && (k - 43) % 6 == 0),
                5'd5, k == 28 || k == 61, (k >= 28 && k < 37) || k >= 61,
                k >= 37);
        run_table("run_early");
        do_reset("d");

        // Period 0 with edge held high, gap at 8, start drop at 15.
        for (int k = 0; k <= 22; k++)
            add(k != 15, k != 8, 5'd0,
                k == 4 || k == 12 || k == 20,
                (k >= 4 && k < 8) || (k >= 12 && k < 15) || k >= 20,
                k >= 8 && k < 15);
        run_table("period0");
        do_reset("end");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
